// File: rtl/ram_ctrl_pkg.sv
// Shared types for the CPU-facing RAM controller: FSM states, port grant, RAM word.
package ram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    typedef enum logic {GNT_I, GNT_D} grant_e;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/cpu_ram_if.sv
// CPU instruction/data port bundle; the CPU is master, the RAM controller is slave.
interface cpu_ram_if;
    import ram_ctrl_pkg::*;

    logic        iren;
    logic [31:0] iaddr;
    word_t       iload;
    logic        iwait;
    logic        dren;
    logic [3:0]  dwen;
    logic [31:0] daddr;
    word_t       dstore;
    word_t       dload;
    logic        dwait;

    modport master (
        output iren, iaddr, dren, dwen, daddr, dstore,
        input  iload, iwait, dload, dwait
    );

    modport slave (
        input  iren, iaddr, dren, dwen, daddr, dstore,
        output iload, iwait, dload, dwait
    );
endinterface

// File: rtl/ram_bank.sv
// Single-port word RAM with byte enables, registered read returning the pre-write word.
module ram_bank
  import ram_ctrl_pkg::*;
#(
  parameter int    ADDR_BITS = 12,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [3:0]           wen_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  word_t                wdata_i,
  output word_t                rdata_o
);
  word_t mem_q [2**ADDR_BITS];
  word_t rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int b = 0; b < 4; b++) begin
        if (wen_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cpu_ram_ctrl.sv
// Arbitrates CPU fetch and data ports onto one RAM bank with LAT-cycle access latency
// and drives the iwait/dwait handshake.
module cpu_ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int    ADDR_BITS = 12,
    parameter int    LAT       = 2,
    parameter string INIT_FILE = ""
) (
    input  logic     clk,
    input  logic     nrst,
    cpu_ram_if.slave bus
);
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_e               state_q, state_d;
    grant_e               grant_q, grant_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 keep_q, keep_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    word_t                wdata_q, wdata_d;
    logic [3:0]           wen_q, wen_d;
    word_t                iload_q, dload_q, rdata;
    logic                 dreq, in_resp, ireq_ok, dreq_ok, present;
    logic                 ack_i, ack_d, ram_en, start;
    logic                 unused_addr_bits;

    assign dreq    = bus.dren | (|bus.dwen);
    assign in_resp = (state_q == RESP);
    // The port answered this cycle still shows its old request; it must not be re-granted.
    assign ireq_ok = bus.iren & ~(in_resp & (grant_q == GNT_I));
    assign dreq_ok = dreq & ~(in_resp & (grant_q == GNT_D));
    assign present = (grant_q == GNT_D) ? dreq : bus.iren;
    assign ack_i   = in_resp & (grant_q == GNT_I) & keep_q & present;
    assign ack_d   = in_resp & (grant_q == GNT_D) & keep_q & present;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        keep_d  = keep_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        start   = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (dreq_ok) begin
                    start   = 1'b1;
                    grant_d = GNT_D;
                    addr_d  = bus.daddr[ADDR_BITS+1:2];
                    wdata_d = bus.dstore;
                    wen_d   = bus.dwen;
                end else if (ireq_ok) begin
                    start   = 1'b1;
                    grant_d = GNT_I;
                    addr_d  = bus.iaddr[ADDR_BITS+1:2];
                    wdata_d = '0;
                    wen_d   = '0;
                end
                if (start) begin
                    cnt_d   = CNT_INIT;
                    keep_d  = 1'b1;
                    state_d = (LAT == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d  = cnt_q - 4'd1;
                keep_d = keep_q & present;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM is accessed on the edge entering RESP; a reset on that edge drops the write.
    assign ram_en = nrst & (state_d == RESP);

    ram_bank #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk     (clk),
        .en_i    (ram_en),
        .wen_i   (wen_d),
        .addr_i  (addr_d),
        .wdata_i (wdata_d),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            grant_q <= GNT_I;
            cnt_q   <= '0;
            keep_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            keep_q  <= keep_d;
            if (ack_i) iload_q <= rdata;
            if (ack_d) dload_q <= rdata;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wen_q   <= wen_d;
    end

    assign bus.iwait = ~ack_i;
    assign bus.dwait = ~ack_d;
    assign bus.iload = ack_i ? rdata : iload_q;
    assign bus.dload = ack_d ? rdata : dload_q;

    assign unused_addr_bits = ^{bus.iaddr[31:ADDR_BITS+2], bus.iaddr[1:0],
                                bus.daddr[31:ADDR_BITS+2], bus.daddr[1:0]};
endmodule

// File: tb/tb_cpu_ram_ctrl.sv
// Bench for cpu_ram_ctrl: three instances with LAT=1,2,3 driven by vector tables and
// hand-written sequences for arbitration, withdrawal and reset.
module tb_cpu_ram_ctrl;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic        iren_a   [3];
    logic [31:0] iaddr_a  [3];
    logic        dren_a   [3];
    logic [3:0]  dwen_a   [3];
    logic [31:0] daddr_a  [3];
    logic [31:0] dstore_a [3];
    logic [31:0] iload_a  [3];
    logic [31:0] dload_a  [3];
    logic        iwait_a  [3];
    logic        dwait_a  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cpu_ram_if bus();
        assign bus.iren   = iren_a[g];
        assign bus.iaddr  = iaddr_a[g];
        assign bus.dren   = dren_a[g];
        assign bus.dwen   = dwen_a[g];
        assign bus.daddr  = daddr_a[g];
        assign bus.dstore = dstore_a[g];
        assign iload_a[g] = bus.iload;
        assign dload_a[g] = bus.dload;
        assign iwait_a[g] = bus.iwait;
        assign dwait_a[g] = bus.dwait;
        cpu_ram_ctrl #(.ADDR_BITS(12), .LAT(g + 1), .INIT_FILE("")) dut (
            .clk  (clk),
            .nrst (nrst),
            .bus  (bus)
        );
    end

    typedef struct {
        bit          is_d;
        bit          rd;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          chk;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    vec_t tbl [14];
    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_port(input int k);
        iren_a[k] = 1'b0; iaddr_a[k] = '0;
        dren_a[k] = 1'b0; dwen_a[k] = '0; daddr_a[k] = '0; dstore_a[k] = '0;
    endtask

    // One request on port I or D of instance k; checks latency and returned word.
    task automatic do_req(input int k, input bit is_d, input bit rd, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input bit chk, input string nm);
        int          n;
        logic        w;
        logic [31:0] got;
        exp_t        e;
        @(negedge clk);
        if (is_d) begin
            dren_a[k] = rd; dwen_a[k] = wen; daddr_a[k] = addr; dstore_a[k] = wdata;
        end else begin
            iren_a[k] = 1'b1; iaddr_a[k] = addr;
        end
        sb.push_back('{is_d ? 0 : 1, exp, chk});
        #1;
        n = 0;
        w = is_d ? dwait_a[k] : iwait_a[k];
        while (w && n < 40) begin
            @(negedge clk); #1;
            n++;
            w = is_d ? dwait_a[k] : iwait_a[k];
        end
        check({nm, "_lat"}, n, k + 1);
        got = is_d ? dload_a[k] : iload_a[k];
        e = sb.pop_front();
        if (e.chk) check({nm, "_data"}, got, e.data);
        @(posedge clk); #1;
        idle_port(k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int          port, exp_port, run_d, max_run_d, lows;
        logic [31:0] got;
        exp_t        e;

        //            is_d rd  wen    addr          wdata          exp            chk
        tbl[0]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0013, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h0000_0013, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'h2, 32'h0000_0021, 32'h0000_AB00, 32'h1122_3344, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'h1122_AB44, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 32'h0000_4010, 32'h0,         32'h0000_0013, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 4'h9, 32'h0000_0023, 32'hAA00_00BB, 32'h1122_AB44, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'hAA22_ABBB, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 4'h4, 32'h0000_0020, 32'h00CC_0000, 32'hAA22_ABBB, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 4'h0, 32'h0000_0020, 32'h0,         32'hAACC_ABBB, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 32'h0000_0022, 32'h0,         32'hAACC_ABBB, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 4'hF, 32'h0000_FFFC, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 32'h0000_3FFC, 32'h0,         32'hDEAD_BEEF, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h0000_0013, 1'b1};

        for (int k = 0; k < 3; k++) idle_port(k);
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d_iwait", k), iwait_a[k], 1'b1);
            check($sformatf("rst%0d_dwait", k), dwait_a[k], 1'b1);
            check($sformatf("rst%0d_iload", k), iload_a[k], 32'h0);
            check($sformatf("rst%0d_dload", k), dload_a[k], 32'h0);
        end
        @(negedge clk);
        nrst = 1'b1;

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 14; i++) begin
                do_req(k, tbl[i].is_d, tbl[i].rd, tbl[i].wen, tbl[i].addr, tbl[i].wdata,
                       tbl[i].exp, tbl[i].chk, $sformatf("L%0d_v%0d", k + 1, i));
            end
        end

        // Simultaneous I and D from IDLE, LAT=1: D first, I chains next cycle.
        @(negedge clk);
        iren_a[0] = 1'b1; iaddr_a[0] = 32'h10;
        dren_a[0] = 1'b1; daddr_a[0] = 32'h10;
        #1;
        check("t3_c0_iwait", iwait_a[0], 1'b1);
        check("t3_c0_dwait", dwait_a[0], 1'b1);
        @(posedge clk); #1;
        check("t3_c1_dwait", dwait_a[0], 1'b0);
        check("t3_c1_iwait", iwait_a[0], 1'b1);
        check("t3_c1_dload", dload_a[0], 32'h13);
        @(posedge clk); #1;
        dren_a[0] = 1'b0;
        #1;
        check("t3_c2_iwait", iwait_a[0], 1'b0);
        check("t3_c2_dwait", dwait_a[0], 1'b1);
        check("t3_c2_iload", iload_a[0], 32'h13);
        @(posedge clk); #1;
        iren_a[0] = 1'b0;
        #1;
        check("t3_c3_iwait", iwait_a[0], 1'b1);
        check("t3_c3_dwait", dwait_a[0], 1'b1);

        // Continuous data stream with fetch pending, LAT=1: strict alternation D, I, ...
        @(negedge clk);
        iren_a[0] = 1'b1; iaddr_a[0] = 32'h10;
        dren_a[0] = 1'b1; daddr_a[0] = 32'h10;
        for (int i = 0; i < 8; i++) sb.push_back('{(i % 2 == 0) ? 0 : 1, 32'h13, 1'b1});
        run_d = 0;
        max_run_d = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            port = !dwait_a[0] ? (!iwait_a[0] ? 3 : 0) : (!iwait_a[0] ? 1 : 2);
            e = sb.pop_front();
            exp_port = e.port;
            check($sformatf("t4_port%0d", i), port, exp_port);
            got = (port == 1) ? iload_a[0] : dload_a[0];
            check($sformatf("t4_data%0d", i), got, e.data);
            run_d = (port == 1) ? 0 : run_d + 1;
            if (run_d > max_run_d) max_run_d = run_d;
        end
        check("t4_max_no_fetch_run", max_run_d, 1);
        idle_port(0);
        repeat (2) @(posedge clk);

        // Write withdrawn during BUSY, LAT=3: no dwait pulse, write still lands.
        do_req(2, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 32'h0, 1'b0, "t5_init");
        @(negedge clk);
        dwen_a[2] = 4'hF; daddr_a[2] = 32'h30; dstore_a[2] = 32'h55AA_55AA;
        @(posedge clk); #1;
        dwen_a[2] = 4'h0;
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!dwait_a[2]) lows++;
            @(posedge clk); #1;
        end
        check("t5_dwait_lows", lows, 0);
        idle_port(2);
        do_req(2, 1'b1, 1'b1, 4'h0, 32'h30, 32'h0, 32'h55AA_55AA, 1'b1, "t5_read");

        // Reset during BUSY of a write, LAT=3: write dropped, outputs cleared, recovery.
        do_req(2, 1'b1, 1'b0, 4'hF, 32'h40, 32'h1234_5678, 32'h0, 1'b0, "t6_init");
        do_req(2, 1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b1, "t6_ird");
        do_req(2, 1'b1, 1'b1, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b1, "t6_drd");
        @(negedge clk);
        dwen_a[2] = 4'hF; daddr_a[2] = 32'h40; dstore_a[2] = 32'hFFFF_FFFF;
        @(negedge clk);
        nrst = 1'b0;
        idle_port(2);
        @(posedge clk); #1;
        check("t6_iwait", iwait_a[2], 1'b1);
        check("t6_dwait", dwait_a[2], 1'b1);
        check("t6_iload", iload_a[2], 32'h0);
        check("t6_dload", dload_a[2], 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        do_req(2, 1'b1, 1'b1, 4'h0, 32'h40, 32'h0, 32'h1234_5678, 1'b1, "t6_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
